crctab_arb: RTL and testbench

Round-robin arbiter and burst sequencer that shares one 256-entry x 32-bit CRC lookup table (combinational read) between NREQ CRC lanes. Each lane issues byte-index lookups with a valid/ready handshake and can hold the table for a multi-lookup burst, such as one slicing step. The block registers the table address and the read data, and returns tagged responses with a fixed latency of 2 cycles. It sits between the pipelined CRC lanes and the shared table instance.

---
 rtl/crctab_pkg.sv | 25 ++
 rtl/crctab_rr_pick.sv | 40 ++++
 rtl/crctab_arb.sv | 213 +++++++++++++++++++++
 tb/tb_crctab_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crctab_pkg.sv
// crctab_pkg: shared types and constants for the crctab_arb table arbiter.
//   crctab_state_e : arbiter FSM state (ST_IDLE, ST_BURST)
//   CRCTAB_IDX_W   : table index width (byte index)
//   CRCTAB_DATA_W  : table entry width
//   crctab_id_w()  : width of a lane identifier for a given lane count
package crctab_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } crctab_state_e;

  localparam int CRCTAB_IDX_W  = 8;
  localparam int CRCTAB_DATA_W = 32;

  // Lane-ID width; never narrower than one bit.
  function automatic int crctab_id_w(input int nreq);
    if (nreq <= 2) begin
      return 1;
    end else begin
      return $clog2(nreq);
    end
  endfunction

endpackage

// File: rtl/crctab_rr_pick.sv
// crctab_rr_pick: combinational round-robin picker.
//   req_valid : per-lane request vector
//   ptr       : last served lane; the scan starts at ptr+1 mod NREQ
//   gnt       : one-hot grant (zero when nothing is requested)
//   gnt_idx   : encoded index of the granted lane
//   gnt_any   : at least one lane is requesting
module crctab_rr_pick
  import crctab_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = crctab_id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [ID_W-1:0] lane;

  // Scan lanes from ptr+1 around to ptr; the first valid lane wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    lane    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      lane = ID_W'((int'(ptr) + k) % NREQ);
      if (!gnt_any && req_valid[lane]) begin
        gnt[lane] = 1'b1;
        gnt_idx   = lane;
        gnt_any   = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/crctab_arb.sv
// crctab_arb: round-robin arbiter and burst sequencer sharing one
// 256 x 32 CRC lookup table between NREQ lanes.
//   clk, rstn              : clock, asynchronous active-low reset
//   req_valid/addr/last    : per-lane lookup requests (addr lane i at [8i+7:8i])
//   req_ready              : per-lane accept, one-hot or zero, same-cycle
//   tab_addr / tab_rdata   : registered table address, combinational read data
//   rsp_valid/id/data      : tagged response, fixed 2-cycle latency, no stall
//   stats_clr / grant_cnt  : per-lane saturating beat counters, only when
//                            CRCTAB_ARB_STATS_EN is defined
module crctab_arb
  import crctab_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 16,
  localparam int ID_W      = crctab_id_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*8-1:0]        req_addr,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [31:0]              tab_addr,
  input  logic [31:0]              tab_rdata,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              rsp_data
`ifdef CRCTAB_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NREQ*16-1:0]       grant_cnt
`endif
);

  localparam logic [ID_W-1:0] PTR_RST   = ID_W'(NREQ - 1);
  localparam logic [7:0]      BURST_LIM = 8'(MAX_BURST);

  crctab_state_e            state_q, state_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [7:0]               beat_cnt_q, beat_cnt_d;
  logic [CRCTAB_IDX_W-1:0]  tab_idx_q, tab_idx_d;
  logic [ID_W-1:0]          id1_q, id1_d;
  logic                     v1_q, v1_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [CRCTAB_DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]          pick_gnt;
  logic [ID_W-1:0]          pick_idx;
  logic                     pick_any;
  logic [NREQ-1:0]          ready_c;
  logic                     acc;
  logic [ID_W-1:0]          acc_lane;
  logic [CRCTAB_IDX_W-1:0]  acc_addr;

  crctab_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .gnt_any   (pick_any)
  );

  // Arbitration FSM: grant selection, burst tracking and release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    ready_c    = '0;
    acc        = 1'b0;
    acc_lane   = '0;
    case (state_q)
      ST_IDLE: begin
        ready_c  = pick_gnt;
        acc      = pick_any;
        acc_lane = pick_idx;
        if (pick_any) begin
          // A single-beat grant (or MAX_BURST=1) releases immediately.
          if (req_last[pick_idx] || (MAX_BURST == 1)) begin
            ptr_d      = pick_idx;
            beat_cnt_d = 8'd0;
          end else begin
            state_d    = ST_BURST;
            owner_d    = pick_idx;
            beat_cnt_d = 8'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        // The owner keeps the grant through gaps; others are blocked.
        ready_c[owner_q] = req_valid[owner_q];
        acc              = req_valid[owner_q];
        acc_lane         = owner_q;
        if (req_valid[owner_q]) begin
          // Forced release is silent: the lane just re-arbitrates.
          if (req_last[owner_q] || ((beat_cnt_q + 8'd1) == BURST_LIM)) begin
            state_d    = ST_IDLE;
            ptr_d      = owner_q;
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lookup pipeline: stage 1 captures address/tag, stage 2 captures data.
  always_comb begin
    acc_addr = req_addr[int'(acc_lane)*8 +: 8];
    v1_d     = acc;
    if (acc) begin
      tab_idx_d = acc_addr;
      id1_d     = acc_lane;
    end else begin
      tab_idx_d = tab_idx_q;
      id1_d     = id1_q;
    end
    rsp_valid_d = v1_q;
    if (v1_q) begin
      rsp_data_d = tab_rdata;
      rsp_id_d   = id1_q;
    end else begin
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= PTR_RST;
      beat_cnt_q  <= 8'd0;
      tab_idx_q   <= '0;
      id1_q       <= '0;
      v1_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      tab_idx_q   <= tab_idx_d;
      id1_q       <= id1_d;
      v1_q        <= v1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = ready_c;
  assign tab_addr  = {24'h000000, tab_idx_q};
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef CRCTAB_ARB_STATS_EN
  logic [15:0] gcnt_q [NREQ];
  logic [15:0] gcnt_d [NREQ];

  // Per-lane accepted-beat counters; clear beats a coincident increment.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      if (stats_clr) begin
        gcnt_d[i] = 16'h0000;
      end else if (ready_c[i] && req_valid[i] && (gcnt_q[i] != 16'hFFFF)) begin
        gcnt_d[i] = gcnt_q[i] + 16'h0001;
      end else begin
        gcnt_d[i] = gcnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        gcnt_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        gcnt_q[i] <= gcnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[i*16 +: 16] = gcnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_crctab_arb.sv
// tb_crctab_arb: directed bench for crctab_arb (NREQ=4, MAX_BURST=16).
// A cycle-level model (owner/pointer/beat count plus a 2-deep response
// history) is compared against the DUT on every negative edge; directed
// sequences add hand-computed literal expectations.
module tb_crctab_arb;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [31:0] tab_addr;
  logic [31:0] tab_rdata;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
`ifdef CRCTAB_ARB_STATS_EN
  logic        stats_clr;
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  crctab_arb #(
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tab_addr  (tab_addr),
    .tab_rdata (tab_rdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef CRCTAB_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table contents: the entries the directed tests rely on, filler elsewhere.
  function automatic logic [31:0] tab_fn(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h00000000;
      8'h01:   return 32'hcd8c54b5;
      8'h02:   return 32'h9fd9b4dd;
      8'h03:   return 32'h5255e068;
      8'hff:   return 32'he735a638;
      default: return {a, ~a, a ^ 8'h5a, 8'h3c};
    endcase
  endfunction

  assign tab_rdata = tab_fn(tab_addr[7:0]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner;   // -1 = nobody holds the table
  int          m_ptr;
  int          m_beats;
  logic        h1_v, h2_v;
  int          h1_lane, h2_lane;
  logic [7:0]  h1_addr, h2_addr;
  logic [7:0]  last_addr;
  logic [31:0] last_data;
  int          last_id;

  always @(negedge clk) begin
    int g;
    if (!rstn) begin
      m_owner   = -1;
      m_ptr     = NREQ - 1;
      m_beats   = 0;
      h1_v      = 1'b0;
      h2_v      = 1'b0;
      h1_lane   = 0;
      h2_lane   = 0;
      h1_addr   = 8'h00;
      h2_addr   = 8'h00;
      last_addr = 8'h00;
      last_data = 32'h0;
      last_id   = 0;
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
      check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
      check("rst_tab_addr", {32'd0, tab_addr}, 64'd0);
    end else begin
      g = -1;
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end else if (req_valid[m_owner]) begin
        g = m_owner;
      end
      check("model_ready", {60'd0, req_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
      check("model_tab_addr", {32'd0, tab_addr}, {56'd0, last_addr});
      check("model_rsp_valid", {63'd0, rsp_valid}, {63'd0, h2_v});
      if (h2_v) begin
        last_data = tab_fn(h2_addr);
        last_id   = h2_lane;
      end
      check("model_rsp_id", {62'd0, rsp_id}, 64'(last_id));
      check("model_rsp_data", {32'd0, rsp_data}, {32'd0, last_data});
      h2_v    = h1_v;
      h2_lane = h1_lane;
      h2_addr = h1_addr;
      h1_v    = (g >= 0);
      if (g >= 0) begin
        h1_lane   = g;
        h1_addr   = req_addr[g*8 +: 8];
        last_addr = req_addr[g*8 +: 8];
        if (m_owner < 0) begin
          m_owner = g;
          m_beats = 0;
        end
        m_beats++;
        if (req_last[g] || m_beats == MAX_BURST) begin
          m_owner = -1;
          m_ptr   = g;
          m_beats = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [3:0] l);
    req_valid = v;
    req_addr  = a;
    req_last  = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    drive(4'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic [31:0] t4_exp [4];

  initial begin
    t4_exp[0] = 32'h00000000;
    t4_exp[1] = 32'hcd8c54b5;
    t4_exp[2] = 32'h9fd9b4dd;
    t4_exp[3] = 32'h5255e068;
    rstn = 1'b0;
    drive(4'h0, 32'h0, 4'h0);
`ifdef CRCTAB_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state, then one single-beat lookup from lane 0.
    @(negedge clk);
    check("reset_ready", {60'd0, req_ready}, 64'd0);
    check("reset_tab_addr", {32'd0, tab_addr}, 64'd0);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    step();
    drive(4'b0001, 32'h00000001, 4'b0001);
    @(negedge clk);
    check("t1_ready", {60'd0, req_ready}, 64'h1);
    step();
    drive(4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_tab_addr", {32'd0, tab_addr}, 64'h1);
    step();
    @(negedge clk);
    check("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t1_rsp_id", {62'd0, rsp_id}, 64'd0);
    check("t1_rsp_data", {32'd0, rsp_data}, 64'hcd8c54b5);

    // All lanes continuously valid with single beats: strict rotation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      drive(4'hf, 32'hffffffff, 4'hf);
      @(negedge clk);
      check("t2_ready", {60'd0, req_ready}, 64'd1 << (i % 4));
      if (i >= 2) begin
        check("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t2_rsp_id", {62'd0, rsp_id}, 64'((i - 2) % 4));
        check("t2_rsp_data", {32'd0, rsp_data}, 64'he735a638);
      end
    end
    step();
    drive(4'h0, 32'h0, 4'h0);

    // Lane 2 holds a 4-beat burst while lane 1 waits.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      drive({1'b0, c <= 3, c >= 1, 1'b0}, {8'h00, 8'(c), 8'hff, 8'h00},
            {1'b0, c == 3, 1'b1, 1'b0});
      @(negedge clk);
      check("t3_ready", {60'd0, req_ready}, (c < 4) ? 64'h4 : 64'h2);
      if (c >= 2) begin
        check("t3_rsp_id", {62'd0, rsp_id}, 64'd2);
        check("t3_rsp_data", {32'd0, rsp_data}, {32'd0, t4_exp[c-2]});
      end
    end
    step();
    drive(4'h0, 32'h0, 4'h0);

    // Lane 3 never signals last: forced release after 16 beats (with one gap).
    do_reset();
    for (int c = 0; c < 21; c++) begin
      step();
      drive({c != 5, 1'b0, 1'b0, c >= 1}, {8'h03, 8'h00, 8'h00, 8'h01}, 4'b0001);
      @(negedge clk);
      if (c == 5)  check("t4_gap_ready", {60'd0, req_ready}, 64'h0);
      if (c == 16) check("t4_last_ready", {60'd0, req_ready}, 64'h8);
      if (c == 17) check("t4_handoff_ready", {60'd0, req_ready}, 64'h1);
      if (c == 18) check("t4_regrant_ready", {60'd0, req_ready}, 64'h8);
    end

    // Reset while two responses are in flight.
    @(posedge clk);
    #1;
    drive(4'h0, 32'h0, 4'h0);
    check("t5_pre_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("t5_async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("t5_async_tab_addr", {32'd0, tab_addr}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    drive(4'b0010, 32'h00000200, 4'b0010);
    @(negedge clk);
    check("t5_ready", {60'd0, req_ready}, 64'h2);
    step();
    drive(4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
    step();
    @(negedge clk);
    check("t5_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t5_rsp_id", {62'd0, rsp_id}, 64'd1);
    check("t5_rsp_data", {32'd0, rsp_data}, 64'h9fd9b4dd);

`ifdef CRCTAB_ARB_STATS_EN
    // Saturation of the lane-0 counter, then clear against a coincident beat.
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      step();
      drive(4'b0001, 32'h00000001, 4'b0001);
    end
    step();
    drive(4'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("st_sat", {48'd0, grant_cnt[15:0]}, 64'hffff);
    check("st_lane1", {48'd0, grant_cnt[31:16]}, 64'h0);
    step();
    drive(4'b0001, 32'h00000001, 4'b0001);
    stats_clr = 1'b1;
    step();
    drive(4'h0, 32'h0, 4'h0);
    stats_clr = 1'b0;
    @(negedge clk);
    check("st_clr", {48'd0, grant_cnt[15:0]}, 64'h0);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
